pipeline_memory_access: RTL and testbench

Memory-stage access controller between the execute/memory pipeline latch and the memory/writeback latch. Launches one data-cache read or write per memory-stage instruction and holds the request until `dhit`. Captures load data and raises a stall request to the hazard unit while the access is outstanding. Latches `halt` so no further data accesses issue once the processor halts.

---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/pipeline_memory_access_if.sv | 34 +++
 rtl/mem_stall_counter.sv | 30 +++
 rtl/pipeline_memory_access.sv | 98 +++++++++
 tb/tb_pipeline_memory_access.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the memory-stage access controller: word type, FSM states
// and the latched request captured at launch.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_DONE   = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic  wr;
    word_t addr;
    word_t data;
  } mem_req_t;

  localparam word_t WORD_MAX = 32'hFFFF_FFFF;

  // A store wins over a load when both flags are set.
  function automatic logic req_is_write(input logic ren, input logic wen);
    return wen | (ren & wen);
  endfunction

endpackage

// File: rtl/pipeline_memory_access_if.sv
// Memory-stage bus: pipeline-latch inputs, data-cache request/response and
// hazard/writeback outputs of the access controller.
interface pipeline_memory_access_if;
  import cpu_types_pkg::*;

  logic  dREN_mem;
  logic  dWEN_mem;
  logic  halt_mem;
  word_t port_o_mem;
  word_t rdat2_mem;
  logic  dhit;
  word_t dmemload;
  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  word_t load_data;
  logic  mem_busy;
  logic  mem_done;
  logic  halt_latched;

  modport master (
    output dREN_mem, dWEN_mem, halt_mem, port_o_mem, rdat2_mem, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, load_data, mem_busy, mem_done,
           halt_latched
  );

  modport slave (
    input  dREN_mem, dWEN_mem, halt_mem, port_o_mem, rdat2_mem, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, load_data, mem_busy, mem_done,
           halt_latched
  );

endinterface

// File: rtl/mem_stall_counter.sv
// Saturating 32-bit event counter; counts every clock edge where en is high.
module mem_stall_counter
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  output word_t count
);

  word_t count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != WORD_MAX)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_memory_access.sv
// Memory-stage access controller: one held cache request per instruction, load
// capture, stall request and sticky halt. MEM_STALL_COUNT_EN adds stall_cycles.
module pipeline_memory_access
  import cpu_types_pkg::*;
(
  input  logic                    CLK,
  input  logic                    nRST,
  pipeline_memory_access_if.slave bus
`ifdef MEM_STALL_COUNT_EN
  ,
  output word_t                   stall_cycles
`endif
);

  mem_state_t state_q, state_d;
  mem_req_t   req_q, req_d;
  word_t      load_data_q, load_data_d;
  logic       halt_q, halt_d;
  logic       launch;
  logic       in_access;
  logic       mem_busy;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    load_data_d = load_data_q;
    halt_d      = halt_q;
    launch      = (bus.dREN_mem | bus.dWEN_mem) & ~bus.halt_mem & ~halt_q;

    case (state_q)
      MEM_IDLE: begin
        if (bus.halt_mem) begin
          halt_d = 1'b1;
        end
        if (launch) begin
          state_d    = MEM_ACCESS;
          req_d.wr   = req_is_write(bus.dREN_mem, bus.dWEN_mem);
          req_d.addr = bus.port_o_mem;
          req_d.data = bus.rdat2_mem;
        end
      end
      MEM_ACCESS: begin
        if (bus.dhit) begin
          state_d = MEM_DONE;
          if (!req_q.wr) begin
            load_data_d = bus.dmemload;
          end
        end
      end
      // Inputs still show the finished instruction here, so nothing may launch.
      MEM_DONE: begin
        state_d = MEM_IDLE;
      end
      default: begin
        state_d = MEM_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= MEM_IDLE;
      req_q       <= '0;
      load_data_q <= '0;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      load_data_q <= load_data_d;
      halt_q      <= halt_d;
    end
  end

  // Cache-facing outputs decode straight from state so reset drops them at once.
  always_comb begin
    in_access = (state_q == MEM_ACCESS);
    mem_busy  = in_access | ((state_q == MEM_IDLE) & launch);
  end

  assign bus.dmemREN      = in_access & ~req_q.wr;
  assign bus.dmemWEN      = in_access & req_q.wr;
  assign bus.dmemaddr     = in_access ? req_q.addr : '0;
  assign bus.dmemstore    = in_access ? req_q.data : '0;
  assign bus.load_data    = load_data_q;
  assign bus.mem_busy     = mem_busy;
  assign bus.mem_done     = (state_q == MEM_DONE);
  assign bus.halt_latched = halt_q;

`ifdef MEM_STALL_COUNT_EN
  mem_stall_counter u_stall_counter (
    .clk   (CLK),
    .rst_n (nRST),
    .en    (mem_busy),
    .count (stall_cycles)
  );
`endif

endmodule

// File: tb/tb_pipeline_memory_access.sv
// Scoreboard bench for pipeline_memory_access: directed accesses push expected
// cache requests and completions; a negedge monitor pops and compares them.
module tb_pipeline_memory_access;
  import cpu_types_pkg::*;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  pipeline_memory_access_if bus_if ();
`ifdef MEM_STALL_COUNT_EN
  word_t stall_cycles;
`endif

  pipeline_memory_access dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus_if)
`ifdef MEM_STALL_COUNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  typedef struct {
    logic  wr;
    word_t addr;
    word_t data;
  } exp_req_t;

  exp_req_t req_exp_q[$];
  word_t    done_exp_q[$];
  word_t    model_load = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int last_done_cycle = -100;
  int done_gap = 0;
  logic prev_req = 1'b0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  always @(posedge CLK) cycle <= cycle + 1;

  // Monitor: first cycle of each cache request and every mem_done pulse.
  always @(negedge CLK) begin
    exp_req_t e;
    word_t    d;
    if ((bus_if.dmemREN || bus_if.dmemWEN) && !prev_req) begin
      if (req_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_req: got ren=%0b wen=%0b addr=0x%08h expected no request",
                 bus_if.dmemREN, bus_if.dmemWEN, bus_if.dmemaddr);
      end else begin
        e = req_exp_q.pop_front();
        check("req_ren", 32'(bus_if.dmemREN), 32'(!e.wr));
        check("req_wen", 32'(bus_if.dmemWEN), 32'(e.wr));
        check("req_addr", bus_if.dmemaddr, e.addr);
        check("req_store", bus_if.dmemstore, e.data);
      end
    end
    prev_req <= bus_if.dmemREN || bus_if.dmemWEN;
    if (bus_if.mem_done) begin
      if (done_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got mem_done=1 expected 0");
      end else begin
        d = done_exp_q.pop_front();
        check("done_load_data", bus_if.load_data, d);
      end
      done_gap        <= cycle - last_done_cycle;
      last_done_cycle <= cycle;
    end
  end

  task automatic clear_inputs();
    bus_if.dREN_mem   = 1'b0;
    bus_if.dWEN_mem   = 1'b0;
    bus_if.halt_mem   = 1'b0;
    bus_if.port_o_mem = '0;
    bus_if.rdat2_mem  = '0;
    bus_if.dhit       = 1'b0;
    bus_if.dmemload   = '0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Presents one instruction at cycle 0; dhit arrives in access cycle hit_at.
  task automatic run_access(input string name, input logic ren, input logic wen,
                            input word_t addr, input word_t data, input int hit_at,
                            input word_t rdata, input logic launches);
    int busy_n = 0;
    int ren_n  = 0;
    int wen_n  = 0;
    int done_n = 0;
    int last;
    bus_if.dREN_mem   = ren;
    bus_if.dWEN_mem   = wen;
    bus_if.halt_mem   = 1'b0;
    bus_if.port_o_mem = addr;
    bus_if.rdat2_mem  = data;
    if (launches) begin
      req_exp_q.push_back('{wen, addr, data});
      if (!wen) model_load = rdata;
      done_exp_q.push_back(model_load);
    end
    last = launches ? hit_at + 1 : 4;
    for (int c = 0; c <= last; c++) begin
      bus_if.dhit     = (c == hit_at);
      bus_if.dmemload = (c == hit_at) ? rdata : 32'hBAD0_BAD0;
      @(negedge CLK);
      busy_n += int'(bus_if.mem_busy);
      ren_n  += int'(bus_if.dmemREN);
      wen_n  += int'(bus_if.dmemWEN);
      done_n += int'(bus_if.mem_done);
      @(posedge CLK);
      #1;
    end
    bus_if.dhit = 1'b0;
    check({name, "_busy_cycles"}, busy_n, launches ? hit_at + 1 : 0);
    check({name, "_ren_cycles"}, ren_n, (launches && !wen) ? hit_at : 0);
    check({name, "_wen_cycles"}, wen_n, (launches && wen) ? hit_at : 0);
    check({name, "_done_pulses"}, done_n, launches ? 1 : 0);
    $display("txn %s: ren=%0b wen=%0b addr=0x%08h busy=%0d ren_cyc=%0d wen_cyc=%0d done=%0d load_data=0x%08h",
             name, ren, wen, addr, busy_n, ren_n, wen_n, done_n, bus_if.load_data);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_dmemREN", 32'(bus_if.dmemREN), 0);
    check("rst_dmemWEN", 32'(bus_if.dmemWEN), 0);
    check("rst_dmemaddr", bus_if.dmemaddr, 0);
    check("rst_load_data", bus_if.load_data, 0);
    check("rst_halt", 32'(bus_if.halt_latched), 0);
    check("rst_done", 32'(bus_if.mem_done), 0);
`ifdef MEM_STALL_COUNT_EN
    check("rst_stall_cycles", stall_cycles, 0);
`endif
    nRST = 1'b1;
    idle(2);

    run_access("load40", 1'b1, 1'b0, 32'h40, 32'h0, 3, 32'hDEAD_BEEF, 1'b1);
    check("load40_load_data", bus_if.load_data, 32'hDEAD_BEEF);
`ifdef MEM_STALL_COUNT_EN
    check("load40_stall_cycles", stall_cycles, 4);
`endif
    idle(2);

    run_access("store80", 1'b0, 1'b1, 32'h80, 32'h1234_5678, 1, 32'h0, 1'b1);
    check("store80_load_kept", bus_if.load_data, 32'hDEAD_BEEF);
    idle(2);

    run_access("b2b_a", 1'b1, 1'b0, 32'h44, 32'h0, 1, 32'h1111_1111, 1'b1);
    run_access("b2b_b", 1'b1, 1'b0, 32'h48, 32'h0, 1, 32'h2222_2222, 1'b1);
    check("b2b_done_gap", done_gap, 3);
    idle(2);

    run_access("both", 1'b1, 1'b1, 32'h100, 32'hCAFE_F00D, 2, 32'hABCD_0123, 1'b1);
    check("both_load_kept", bus_if.load_data, 32'h2222_2222);
    idle(2);

    // Reset lands in the second access cycle of a load that never hits.
    bus_if.dREN_mem   = 1'b1;
    bus_if.port_o_mem = 32'h200;
    req_exp_q.push_back('{1'b0, 32'h200, 32'h0});
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    check("rst_mid_pre_ren", 32'(bus_if.dmemREN), 1);
    nRST = 1'b0;
    clear_inputs();
    #1;
    check("rst_mid_ren", 32'(bus_if.dmemREN), 0);
    check("rst_mid_wen", 32'(bus_if.dmemWEN), 0);
    check("rst_mid_addr", bus_if.dmemaddr, 0);
    check("rst_mid_busy", 32'(bus_if.mem_busy), 0);
    check("rst_mid_load_data", bus_if.load_data, 0);
`ifdef MEM_STALL_COUNT_EN
    check("rst_mid_stall_cycles", stall_cycles, 0);
`endif
    model_load = '0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    idle(1);
    run_access("post_rst_load", 1'b1, 1'b0, 32'h300, 32'h0, 1, 32'h55AA_55AA, 1'b1);
    idle(2);

    // Halt together with a load: nothing launches and halt sticks.
    bus_if.halt_mem   = 1'b1;
    bus_if.dREN_mem   = 1'b1;
    bus_if.port_o_mem = 32'h400;
    @(negedge CLK);
    check("halt_busy", 32'(bus_if.mem_busy), 0);
    check("halt_ren", 32'(bus_if.dmemREN), 0);
    @(posedge CLK);
    #1;
    check("halt_latched", 32'(bus_if.halt_latched), 1);
    run_access("after_halt", 1'b1, 1'b0, 32'h404, 32'h0, 1, 32'h7777_7777, 1'b0);
    check("after_halt_sticky", 32'(bus_if.halt_latched), 1);
    check("after_halt_load_kept", bus_if.load_data, 32'h55AA_55AA);
    idle(2);

    check("req_queue_drained", req_exp_q.size(), 0);
    check("done_queue_drained", done_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
